alu_seq: RTL and testbench

Programmable micro-sequencer that drives the shared operand RAM and the modular ALU (FA/MUL/INV) of the ECC signing core. It replaces the fixed r/s/k⁻¹ sequences with a loadable program memory of three-address steps `dst = op(srcA, srcB)`. A program is started at any entry point and runs until its last-flagged step. A watchdog, abort and error reporting are included. Register-file width, RAM address width and program depth are parameters.

---
 rtl/alu_seq_if.sv | 37 +++
 rtl/alu_seq.sv | 148 ++++++++++++++
 tb/tb_alu_seq.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Bus bundle between the alu_seq micro-sequencer and its environment:
// program load, run control, operand RAM side and modular ALU side.
interface alu_seq_if #(
    parameter int WID   = 256,
    parameter int AWID  = 5,
    parameter int PAWID = 4
);
    localparam int IW = 3 + 3 * AWID;

    logic             pwe;
    logic [PAWID-1:0] pwa;
    logic [IW-1:0]    pwd;
    logic             start;
    logic [PAWID-1:0] entry;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic [AWID-1:0]  ramra;
    logic [WID-1:0]   ramwd;
    logic [AWID-1:0]  ramwa;
    logic             ramwe;
    logic             aen;
    logic [1:0]       aop;
    logic [WID-1:0]   adi;
    logic             adivld;

    modport master (
        output pwe, pwa, pwd, start, entry, abort, adi, adivld,
        input  busy, done, err, ramra, ramwd, ramwa, ramwe, aen, aop
    );

    modport slave (
        input  pwe, pwa, pwd, start, entry, abort, adi, adivld,
        output busy, done, err, ramra, ramwd, ramwa, ramwe, aen, aop
    );
endinterface

// File: rtl/alu_seq.sv
// Programmable three-address micro-sequencer: dst = op(srcA, srcB) steps read
// from a loadable program memory, driving the operand RAM and modular ALU.
module alu_seq #(
    parameter int WID       = 256,
    parameter int AWID      = 5,
    parameter int PAWID     = 4,
    parameter int TMO       = 4095,
    parameter int ZR_ADDR   = 18,
    parameter int BLNK_ADDR = 31
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int IW   = 3 + 3 * AWID;
    localparam int PDEP = 2 ** PAWID;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LDA,
        S_LDB,
        S_WAIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IW-1:0]    r_pmem [PDEP];
    logic [IW-1:0]    r_instr;
    logic [PAWID-1:0] r_pc;
    logic [15:0]      r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [AWID-1:0]  r_ramra;
    logic [WID-1:0]   r_ramwd;
    logic [AWID-1:0]  r_ramwa;
    logic             r_ramwe;
    logic             r_aen;
    logic [1:0]       r_aop;

    logic [AWID-1:0]  w_srca;
    logic [AWID-1:0]  w_srcb;
    logic [AWID-1:0]  w_dst;
    logic [1:0]       w_op;
    logic             w_last;
    logic             w_wr;
    logic             w_tmo;
    logic             w_go;

    assign w_srca = r_instr[AWID-1:0];
    assign w_srcb = r_instr[2*AWID-1:AWID];
    assign w_dst  = r_instr[3*AWID-1:2*AWID];
    assign w_op   = r_instr[3*AWID+1:3*AWID];
    assign w_last = r_instr[3*AWID+2];

    assign w_go  = (r_state == S_IDLE) && bus.start && !bus.abort;
    // Abort outranks both a returning result and an expiring watchdog.
    assign w_wr  = (r_state == S_WAIT) && bus.adivld && !bus.abort;
    assign w_tmo = (r_state == S_WAIT) && !bus.adivld && !bus.abort &&
                   (r_cnt == 16'(TMO - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_next = S_FETCH;
            S_FETCH: w_next = bus.abort ? S_IDLE : S_LDA;
            S_LDA:   w_next = bus.abort ? S_IDLE : S_LDB;
            S_LDB:   w_next = bus.abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (bus.abort)       w_next = S_IDLE;
                else if (bus.adivld) w_next = w_last ? S_IDLE : S_FETCH;
                else if (w_tmo)      w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Program store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (bus.pwe && (r_state == S_IDLE))
            r_pmem[bus.pwa] <= bus.pwd;
        if (r_state == S_FETCH)
            r_instr <= r_pmem[r_pc];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ramra <= AWID'(ZR_ADDR);
            r_ramwd <= '0;
            r_ramwa <= AWID'(BLNK_ADDR);
            r_ramwe <= 1'b0;
            r_aen   <= 1'b0;
            r_aop   <= 2'b00;
        end else begin
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_wr && w_last) || w_tmo;
            r_err   <= w_tmo;
            r_ramwe <= w_wr;
            r_ramwa <= w_wr ? w_dst : AWID'(BLNK_ADDR);
            if (w_wr)
                r_ramwd <= bus.adi;

            if (w_go)
                r_pc <= bus.entry;
            else if (w_wr && !w_last)
                r_pc <= r_pc + PAWID'(1);

            // Operand addresses and the ALU start are staged one cycle ahead
            // so they are visible in LDB / first WAIT cycle respectively.
            r_ramra <= AWID'(ZR_ADDR);
            r_aen   <= 1'b0;
            if ((r_state == S_LDA) && (w_next == S_LDB)) begin
                r_ramra <= w_srca;
                r_aen   <= 1'b1;
                r_aop   <= w_op;
            end else if ((r_state == S_LDB) && (w_next == S_WAIT)) begin
                r_ramra <= (w_op == 2'b10) ? w_srca : w_srcb;
            end

            if (r_state == S_LDB)
                r_cnt <= '0;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt + 16'd1;
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.err   = r_err;
    assign bus.ramra = r_ramra;
    assign bus.ramwd = r_ramwd;
    assign bus.ramwa = r_ramwa;
    assign bus.ramwe = r_ramwe;
    assign bus.aen   = r_aen;
    assign bus.aop   = r_aop;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: table of single-step programs plus hand-written
// multi-step, wrap, timeout, abort, busy-lockout and reset sequences.
module tb_alu_seq;
    localparam int WID  = 32;
    localparam int AWID = 5;
    localparam int PAW  = 4;
    localparam int ZR   = 18;
    localparam int BLNK = 31;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WID(WID), .AWID(AWID), .PAWID(PAW)) bus ();

    alu_seq #(
        .WID(WID), .AWID(AWID), .PAWID(PAW), .TMO(8),
        .ZR_ADDR(ZR), .BLNK_ADDR(BLNK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [1:0]  op;
        logic [4:0]  dst;
        logic [4:0]  srcb;
        logic [4:0]  srca;
        int          lat;
        logic [31:0] adi;
        logic [4:0]  exp_rb;
        logic [4:0]  exp_wa;
    } vec_t;

    vec_t vecs [4];

    int          s_aen, s_done, s_err, s_wr, aen_cyc, done_cyc;
    logic [4:0]  wa_q [8];
    logic [31:0] wd_q [8];
    logic [4:0]  ra_q [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] mk(input logic l, input logic [1:0] op,
                                       input logic [4:0] d, input logic [4:0] b,
                                       input logic [4:0] a);
        return {l, op, d, b, a};
    endfunction

    task automatic load(input logic [3:0] a, input logic [17:0] w);
        bus.pwe = 1'b1;
        bus.pwa = a;
        bus.pwd = w;
        step();
        bus.pwe = 1'b0;
    endtask

    // Runs a program from ent; a simple ALU answers each aen after lat cycles
    // (lat=0: never answers) with A000 + step number.
    task automatic run_seq(input logic [3:0] ent, input int lat);
        int cd;
        logic [31:0] nxt;
        cd = 0; nxt = '0;
        s_aen = 0; s_done = 0; s_err = 0; s_wr = 0; aen_cyc = -1; done_cyc = -1;
        bus.entry = ent;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.pwe   = 1'b0;
        for (int c = 1; c < 80; c++) begin
            bus.adivld = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.adivld = 1'b1;
                    bus.adi    = nxt;
                end
            end
            if (bus.aen) begin
                if (s_aen < 8) ra_q[s_aen] = bus.ramra;
                s_aen++;
                nxt = 32'hA000 + 32'(s_aen);
                cd = lat;
                aen_cyc = c;
            end
            if (bus.ramwe) begin
                if (s_wr < 8) begin
                    wa_q[s_wr] = bus.ramwa;
                    wd_q[s_wr] = bus.ramwd;
                end
                s_wr++;
            end
            if (bus.done) begin
                s_done++;
                done_cyc = c;
                if (bus.err) s_err++;
            end
            if (done_cyc >= 0 && c > done_cyc + 2) break;
            step();
        end
        bus.adivld = 1'b0;
        chk("seq_terminated", 64'(done_cyc >= 0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.pwe = 0; bus.pwa = '0; bus.pwd = '0; bus.start = 0; bus.entry = '0;
        bus.abort = 0; bus.adi = '0; bus.adivld = 0;

        vecs[0] = '{4'd0,  2'b00, 5'd13, 5'd18, 5'd15, 3, 32'h0000_1234, 5'd18, 5'd13};
        vecs[1] = '{4'd3,  2'b01, 5'd29, 5'd17, 5'd13, 1, 32'hDEAD_BEEF, 5'd17, 5'd29};
        vecs[2] = '{4'd9,  2'b10, 5'd12, 5'd7,  5'd11, 5, 32'h0000_0001, 5'd11, 5'd12};
        vecs[3] = '{4'd15, 2'b11, 5'd1,  5'd2,  5'd3,  2, 32'hFFFF_FFFF, 5'd2,  5'd1};

        repeat (3) step();
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_done",  64'(bus.done),  64'd0);
        chk("rst_err",   64'(bus.err),   64'd0);
        chk("rst_aen",   64'(bus.aen),   64'd0);
        chk("rst_aop",   64'(bus.aop),   64'd0);
        chk("rst_ramwe", 64'(bus.ramwe), 64'd0);
        chk("rst_ramra", 64'(bus.ramra), 64'(ZR));
        chk("rst_ramwa", 64'(bus.ramwa), 64'(BLNK));
        chk("rst_ramwd", 64'(bus.ramwd), 64'd0);
        rst = 1'b0;
        step();

        // Single-step table: start at cycle 0, aen at 3, adivld at 3+lat.
        for (int i = 0; i < 4; i++) begin
            vec_t v;
            int c;
            v = vecs[i];
            load(v.addr, mk(1'b1, v.op, v.dst, v.srcb, v.srca));
            bus.entry = v.addr;
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            chk("v_busy_c1", 64'(bus.busy), 64'd1);
            step();
            chk("v_aen_c2", 64'(bus.aen), 64'd0);
            step();
            chk("v_aen_c3", 64'(bus.aen), 64'd1);
            chk("v_ra_c3",  64'(bus.ramra), 64'(v.srca));
            chk("v_aop_c3", 64'(bus.aop), 64'(v.op));
            step();
            chk("v_aen_c4", 64'(bus.aen), 64'd0);
            chk("v_ra_c4",  64'(bus.ramra), 64'(v.exp_rb));
            c = 4;
            while (c < 3 + v.lat) begin
                step();
                c++;
                chk("v_aop_wait", 64'(bus.aop), 64'(v.op));
                chk("v_we_wait",  64'(bus.ramwe), 64'd0);
            end
            bus.adivld = 1'b1;
            bus.adi    = v.adi;
            step();
            bus.adivld = 1'b0;
            chk("v_ramwe", 64'(bus.ramwe), 64'd1);
            chk("v_ramwa", 64'(bus.ramwa), 64'(v.exp_wa));
            chk("v_ramwd", 64'(bus.ramwd), 64'(v.adi));
            chk("v_done",  64'(bus.done),  64'd1);
            chk("v_err",   64'(bus.err),   64'd0);
            chk("v_busy",  64'(bus.busy),  64'd0);
            step();
            chk("v_done_off",  64'(bus.done),  64'd0);
            chk("v_ramwe_off", 64'(bus.ramwe), 64'd0);
            chk("v_ramwa_idle", 64'(bus.ramwa), 64'(BLNK));
            chk("v_ramra_idle", 64'(bus.ramra), 64'(ZR));
        end

        // Three-step s-sequence at entry 5.
        load(4'd5, mk(1'b0, 2'b01, 5'd29, 5'd17, 5'd13));
        load(4'd6, mk(1'b0, 2'b00, 5'd30, 5'd16, 5'd29));
        load(4'd7, mk(1'b1, 2'b01, 5'd14, 5'd12, 5'd30));
        run_seq(4'd5, 2);
        chk("s3_aen",  64'(s_aen),  64'd3);
        chk("s3_done", 64'(s_done), 64'd1);
        chk("s3_err",  64'(s_err),  64'd0);
        chk("s3_nwr",  64'(s_wr),   64'd3);
        chk("s3_wa0",  64'(wa_q[0]), 64'd29);
        chk("s3_wa1",  64'(wa_q[1]), 64'd30);
        chk("s3_wa2",  64'(wa_q[2]), 64'd14);
        chk("s3_wd0",  64'(wd_q[0]), 64'h0000_A001);
        chk("s3_wd2",  64'(wd_q[2]), 64'h0000_A003);

        // Program counter wrap 15 -> 0.
        load(4'd15, mk(1'b0, 2'b00, 5'd3, 5'd2, 5'd1));
        load(4'd0,  mk(1'b1, 2'b01, 5'd4, 5'd6, 5'd5));
        run_seq(4'd15, 1);
        chk("wrap_nwr", 64'(s_wr),    64'd2);
        chk("wrap_wa0", 64'(wa_q[0]), 64'd3);
        chk("wrap_wa1", 64'(wa_q[1]), 64'd4);
        chk("wrap_ra1", 64'(ra_q[1]), 64'd5);

        // Watchdog: no ALU answer.
        load(4'd8, mk(1'b1, 2'b00, 5'd10, 5'd9, 5'd8));
        run_seq(4'd8, 0);
        chk("tmo_err",   64'(s_err),  64'd1);
        chk("tmo_done",  64'(s_done), 64'd1);
        chk("tmo_nwr",   64'(s_wr),   64'd0);
        chk("tmo_delay", 64'(done_cyc - aen_cyc), 64'd9);

        // Abort together with adivld, then a stray adivld while idle.
        load(4'd2, mk(1'b1, 2'b00, 5'd9, 5'd8, 5'd7));
        bus.entry = 4'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("ab_aen", 64'(bus.aen), 64'd1);
        step();
        step();
        bus.adivld = 1'b1; bus.abort = 1'b1; bus.adi = 32'h7777;
        step();
        bus.adivld = 1'b0; bus.abort = 1'b0;
        chk("ab_ramwe", 64'(bus.ramwe), 64'd0);
        chk("ab_done",  64'(bus.done),  64'd0);
        chk("ab_busy",  64'(bus.busy),  64'd0);
        chk("ab_ramwa", 64'(bus.ramwa), 64'(BLNK));
        bus.adivld = 1'b1;
        step();
        bus.adivld = 1'b0;
        chk("stray_ramwe", 64'(bus.ramwe), 64'd0);
        chk("stray_done",  64'(bus.done),  64'd0);

        // Abort with start in idle: start ignored.
        bus.start = 1'b1; bus.abort = 1'b1;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("abst_busy", 64'(bus.busy), 64'd0);

        // start and pwe while busy are dropped.
        bus.entry = 4'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        bus.start = 1'b1; bus.entry = 4'd8;
        bus.pwe = 1'b1; bus.pwa = 4'd2; bus.pwd = mk(1'b1, 2'b00, 5'd22, 5'd21, 5'd20);
        step();
        bus.start = 1'b0; bus.pwe = 1'b0;
        chk("bz_busy", 64'(bus.busy), 64'd1);
        bus.adivld = 1'b1; bus.adi = 32'h5555;
        step();
        bus.adivld = 1'b0;
        chk("bz_ramwe", 64'(bus.ramwe), 64'd1);
        chk("bz_ramwa", 64'(bus.ramwa), 64'd9);
        chk("bz_done",  64'(bus.done),  64'd1);
        begin
            int extra_aen;
            extra_aen = 0;
            for (int k = 0; k < 6; k++) begin
                step();
                if (bus.aen) extra_aen++;
            end
            chk("bz_start_ignored", 64'(extra_aen), 64'd0);
        end
        run_seq(4'd2, 2);
        chk("bz_pmem_kept", 64'(wa_q[0]), 64'd9);

        // pwe and start in the same idle cycle: new content executes.
        load(4'd4, mk(1'b1, 2'b00, 5'd25, 5'd24, 5'd23));
        bus.pwe = 1'b1; bus.pwa = 4'd4; bus.pwd = mk(1'b1, 2'b01, 5'd21, 5'd20, 5'd19);
        run_seq(4'd4, 2);
        chk("pwst_wa", 64'(wa_q[0]), 64'd21);
        chk("pwst_ra", 64'(ra_q[0]), 64'd19);

        // Reset in the middle of a program.
        bus.entry = 4'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        chk("mrst_busy",  64'(bus.busy),  64'd0);
        chk("mrst_aen",   64'(bus.aen),   64'd0);
        chk("mrst_ramra", 64'(bus.ramra), 64'(ZR));
        chk("mrst_aop",   64'(bus.aop),   64'd0);
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
